vspi_cmd_decoder: RTL and testbench
===================================

VSPI_CMD_DECODER -- requirements
Module: vspi_cmd_decoder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, memory byte-address width (4096 bytes).
REQ-002 SHALL have parameter MIN_GAP, default 4, minimum SysClk cycles between rx_valid pulses that the block must tolerate.
REQ-003 SysClk  in  1  single system clock; all logic on rising edge.
REQ-004 Reset_n  in  1  reset, synchronous, active-low.
REQ-005 frame_active  in  1  high while SPI slave-select asserted (already synchronized upstream).
REQ-006 rx_valid  in  1  one-cycle pulse: complete byte received from SPI byte layer.
REQ-007 rx_byte  in  8  received byte; valid when rx_valid high.
REQ-008 tx_byte  out  8  registered byte the byte layer shifts out on the next SPI byte.
REQ-009 reg_we  out  1  register-file write strobe, one cycle.
REQ-010 reg_addr  out  4  register index.
REQ-011 reg_wdata  out  32  register write data.
REQ-012 reg_rdata  in  32  register read data, combinational from reg_addr.
REQ-013 mem_we  out  1  memory write strobe, one cycle.
REQ-014 mem_addr  out  MEM_AW  memory byte address.
REQ-015 mem_wdata  out  8  memory write data.
REQ-016 mem_rdata  in  8  memory read data, one-cycle synchronous latency from mem_addr.
REQ-017 cmd_err  out  1  one-cycle pulse on unknown opcode.

Function
REQ-018 First rx_byte of a frame is the opcode: bits[7:4] command, bits[3:0] register index.
REQ-019 Commands: 0x1 WRITE_REG, 0x2 READ_REG, 0x3 WRITE_MEM, 0x4 READ_MEM; any other value is unknown.
REQ-020 FSM states: IDLE, WREG, RREG, WMEM, RMEM, DISCARD; IDLE awaits the opcode.
REQ-021 IDLE + rx_valid: opcode 1/2/3/4 -> WREG/RREG/WMEM/RMEM; unknown -> DISCARD, cmd_err pulses next cycle.
REQ-022 Any state: frame_active low -> IDLE next cycle; pending partial WREG word discarded, no write.
REQ-023 WREG: collects 4 data bytes MSB first; cycle after 4th rx_valid, reg_we=1 one cycle with reg_addr=index, reg_wdata=word; further bytes ignored.
REQ-024 RREG: cycle after opcode rx_valid, reg_rdata latched; tx_byte=bits[31:24]; each following rx_valid advances tx_byte to next lower byte; after 4th, tx_byte=0x00.
REQ-025 Memory pointer cleared to 0 on every accepted opcode; increments by 1 per data byte; wraps 4095->0 without error.
REQ-026 WMEM: cycle after each data rx_valid, mem_we=1, mem_addr=pointer, mem_wdata=rx_byte; pointer increments same edge.
REQ-027 RMEM: mem_addr=0 driven cycle after opcode; tx_byte=mem_rdata two cycles after opcode rx_valid; each later rx_valid advances pointer and updates tx_byte within 2 cycles.
REQ-028 tx_byte=0x00 in IDLE, WREG, WMEM, DISCARD.
REQ-029 rx_valid coinciding with frame_active low is ignored.
REQ-030 All outputs registered; reg_we and mem_we never high in the same cycle.

Reset
REQ-031 Reset_n low at a SysClk edge: state IDLE, pointer 0, all outputs 0 next cycle, regardless of state or frame.
REQ-032 Reset mid-frame: remaining bytes of that frame ignored until frame_active falls and rises again.

Structure
REQ-033 Opcode constants, FSM state encoding and MEM_AW default SHALL live in shared package vspi_pkg.
REQ-034 Single module; no sub-module; pointer and byte shifter inline.

Verification
REQ-035 Frame 0x15,DE,AD,BE,EF -> one reg_we pulse, reg_addr=5, reg_wdata=0xDEADBEEF.
REQ-036 Frame 0x2A with reg_rdata=0x12345678, 4 dummy bytes -> tx_byte sequence 0x12,0x34,0x56,0x78, then 0x00.
REQ-037 Frame 0x30 + 4097 bytes with value i[7:0] -> writes addr 0..4095 then addr 0 gets 0x00 (wrap); 4097 mem_we pulses.
REQ-038 Frame 0x40 with memory preloaded mem[n]=n[7:0], 3 dummy bytes -> tx_byte 0x00,0x01,0x02 at successive byte boundaries.
REQ-039 Frame 0x17,0x11,0x22 then frame_active low -> no reg_we; next frame 0x90 -> cmd_err pulse, later bytes ignored.
REQ-040 Reset_n low during WMEM after 2 bytes -> outputs 0, IDLE; subsequent bytes same frame produce no mem_we.

Source files
------------

// File: rtl/vspi_pkg.sv
// Shared definitions for the VSPI command decoder: opcodes, FSM encoding
// and the default memory address width.
package vspi_pkg;

  localparam int MEM_AW_DEFAULT = 12;

  localparam logic [3:0] OP_WRITE_REG = 4'h1;
  localparam logic [3:0] OP_READ_REG  = 4'h2;
  localparam logic [3:0] OP_WRITE_MEM = 4'h3;
  localparam logic [3:0] OP_READ_MEM  = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WREG    = 3'd1,
    ST_RREG    = 3'd2,
    ST_WMEM    = 3'd3,
    ST_RMEM    = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  // Map the command nibble of an opcode byte to the state that serves it.
  function automatic state_t op_to_state(input logic [3:0] op);
    state_t st;
    case (op)
      OP_WRITE_REG: st = ST_WREG;
      OP_READ_REG:  st = ST_RREG;
      OP_WRITE_MEM: st = ST_WMEM;
      OP_READ_MEM:  st = ST_RMEM;
      default:      st = ST_DISCARD;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/vspi_cmd_decoder.sv
// VSPI command decoder: turns the byte stream of one SPI frame into
// register-file and memory accesses, and supplies the read-back byte.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the opcode byte of a frame
// WREG    | collecting 4 data bytes (MSB first) for a register write
// RREG    | shifting a latched register word out on tx_byte
// WMEM    | each data byte written to memory at the auto-incrementing pointer
// RMEM    | each dummy byte advances the pointer; tx_byte follows mem_rdata
// DISCARD | unknown opcode seen; rest of frame ignored
module vspi_cmd_decoder
  import vspi_pkg::*;
#(
  parameter int MEM_AW  = MEM_AW_DEFAULT,
  parameter int MIN_GAP = 4
) (
  input  logic              SysClk,
  input  logic              Reset_n,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              reg_we,
  output logic [3:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_err
);

  // The read-memory path needs two cycles from a byte pulse to a fresh
  // tx_byte, so pulses closer than that cannot be honoured.
  if (MIN_GAP < 2) begin : g_gap_check
    $error("vspi_cmd_decoder: MIN_GAP must be at least 2");
  end

  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

  state_t            state_q, state_d;
  logic              blocked_q, blocked_d;   // frame cut by reset; wait for its end
  logic [2:0]        cnt_q, cnt_d;           // data bytes collected in WREG
  logic [31:0]       wr_word_q, wr_word_d;
  logic [31:0]       rd_word_q, rd_word_d;
  logic              rr_load_q, rr_load_d;   // reg_addr now valid, latch reg_rdata
  logic              rm_p1_q, rm_p1_d;       // mem_addr just updated
  logic              rm_p2_q, rm_p2_d;       // mem_rdata now valid for that address
  logic [MEM_AW-1:0] ptr_q, ptr_d;

  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              reg_we_q, reg_we_d;
  logic [3:0]        reg_addr_q, reg_addr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cmd_err_q, cmd_err_d;

  // State register and registered outputs, synchronous active-low reset.
  always_ff @(posedge SysClk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      blocked_q   <= 1'b1;
      cnt_q       <= '0;
      wr_word_q   <= '0;
      rd_word_q   <= '0;
      rr_load_q   <= 1'b0;
      rm_p1_q     <= 1'b0;
      rm_p2_q     <= 1'b0;
      ptr_q       <= '0;
      tx_byte_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      blocked_q   <= blocked_d;
      cnt_q       <= cnt_d;
      wr_word_q   <= wr_word_d;
      rd_word_q   <= rd_word_d;
      rr_load_q   <= rr_load_d;
      rm_p1_q     <= rm_p1_d;
      rm_p2_q     <= rm_p2_d;
      ptr_q       <= ptr_d;
      tx_byte_q   <= tx_byte_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    blocked_d   = blocked_q & frame_active;
    cnt_d       = cnt_q;
    wr_word_d   = wr_word_q;
    rd_word_d   = rd_word_q;
    rr_load_d   = 1'b0;
    rm_p1_d     = 1'b0;
    rm_p2_d     = rm_p1_q;
    ptr_d       = ptr_q;
    tx_byte_d   = tx_byte_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_err_d   = 1'b0;

    if (!frame_active) begin
      // Frame over: drop any partial register word, bytes now ignored.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && !blocked_q) begin
            state_d   = op_to_state(rx_byte[7:4]);
            ptr_d     = '0;
            cnt_d     = '0;
            wr_word_d = '0;
            if (state_d == ST_DISCARD) begin
              cmd_err_d = 1'b1;
            end else begin
              reg_addr_d = rx_byte[3:0];
            end
            if (state_d == ST_RREG) begin
              rr_load_d = 1'b1;
            end
            if (state_d == ST_RMEM) begin
              mem_addr_d = '0;
              rm_p1_d    = 1'b1;
            end
          end
        end

        ST_WREG: begin
          if (rx_valid && (cnt_q < 3'd4)) begin
            wr_word_d = {wr_word_q[23:0], rx_byte};
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = {wr_word_q[23:0], rx_byte};
            end
          end
        end

        ST_RREG: begin
          if (rr_load_q) begin
            rd_word_d = reg_rdata;
            tx_byte_d = reg_rdata[31:24];
          end else if (rx_valid) begin
            rd_word_d = {rd_word_q[23:0], 8'h00};
            tx_byte_d = rd_word_q[23:16];
          end
        end

        ST_WMEM: begin
          if (rx_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = rx_byte;
            ptr_d       = ptr_q + PTR_ONE;
          end
        end

        ST_RMEM: begin
          if (rm_p2_q) begin
            tx_byte_d = mem_rdata;
          end
          if (rx_valid) begin
            ptr_d      = ptr_q + PTR_ONE;
            mem_addr_d = ptr_q + PTR_ONE;
            rm_p1_d    = 1'b1;
          end
        end

        default: begin
        end
      endcase
    end

    // Only the read states drive data back to the master.
    if ((state_d != ST_RREG) && (state_d != ST_RMEM)) begin
      tx_byte_d = 8'h00;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_vspi_cmd_decoder.sv
// Directed bench for vspi_cmd_decoder with a register-file and a
// synchronous-read memory model.
module tb_vspi_cmd_decoder;

  localparam int MEM_AW = 12;
  localparam int GAP    = 4;

  logic              SysClk = 1'b0;
  logic              Reset_n;
  logic              frame_active;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              reg_we;
  logic [3:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] reg_model [0:15];
  logic [7:0]  mem_model [0:4095];

  int                reg_we_cnt  = 0;
  int                mem_we_cnt  = 0;
  int                cmd_err_cnt = 0;
  int                both_cnt    = 0;
  logic [3:0]        last_reg_addr;
  logic [31:0]       last_reg_wdata;
  logic [MEM_AW-1:0] last_mem_addr;
  logic [7:0]        last_mem_wdata;

  vspi_cmd_decoder #(.MEM_AW(MEM_AW), .MIN_GAP(GAP)) dut (
    .SysClk       (SysClk),
    .Reset_n      (Reset_n),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cmd_err      (cmd_err)
  );

  always #5 SysClk = ~SysClk;

  assign reg_rdata = reg_model[reg_addr];

  always @(posedge SysClk) mem_rdata <= mem_model[mem_addr];

  // Strobe monitor, sampled on the falling edge.
  always @(negedge SysClk) begin
    if (reg_we) begin
      reg_we_cnt     = reg_we_cnt + 1;
      last_reg_addr  = reg_addr;
      last_reg_wdata = reg_wdata;
    end
    if (mem_we) begin
      mem_we_cnt     = mem_we_cnt + 1;
      last_mem_addr  = mem_addr;
      last_mem_wdata = mem_wdata;
    end
    if (cmd_err) cmd_err_cnt = cmd_err_cnt + 1;
    if (reg_we && mem_we) both_cnt = both_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge SysClk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge SysClk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (GAP) @(negedge SysClk);
    #1;
  endtask

  task automatic start_frame();
    @(negedge SysClk);
    frame_active = 1'b1;
    repeat (2) @(negedge SysClk);
    #1;
  endtask

  task automatic end_frame();
    @(negedge SysClk);
    frame_active = 1'b0;
    repeat (2) @(negedge SysClk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge SysClk);
    #1;
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
    checks++; if (reg_addr !== 4'h0) begin errors++; $display("FAIL reset_reg_addr got %h want 0", reg_addr); end
    checks++; if (reg_wdata !== 32'h0) begin errors++; $display("FAIL reset_reg_wdata got %h want 0", reg_wdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
    @(negedge SysClk);
    Reset_n = 1'b1;
    repeat (2) @(negedge SysClk);
  endtask

  task automatic test_write_reg();
    int base = reg_we_cnt;
    start_frame();
    send_byte(8'h15);
    send_byte(8'hDE);
    send_byte(8'hAD);
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL wreg_tx_zero got %h want 00", tx_byte); end
    send_byte(8'hBE);
    checks++; if (reg_we_cnt - base !== 0) begin errors++; $display("FAIL wreg_early got %0d want 0", reg_we_cnt - base); end
    send_byte(8'hEF);
    checks++; if (reg_we_cnt - base !== 1) begin errors++; $display("FAIL wreg_count got %0d want 1", reg_we_cnt - base); end
    checks++; if (last_reg_addr !== 4'h5) begin errors++; $display("FAIL wreg_addr got %h want 5", last_reg_addr); end
    checks++; if (last_reg_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wreg_wdata got %h want deadbeef", last_reg_wdata); end
    send_byte(8'h55);
    checks++; if (reg_we_cnt - base !== 1) begin errors++; $display("FAIL wreg_extra_ignored got %0d want 1", reg_we_cnt - base); end
    end_frame();
  endtask

  task automatic test_read_reg();
    logic [7:0] exp_seq [0:4];
    exp_seq[0] = 8'h34; exp_seq[1] = 8'h56; exp_seq[2] = 8'h78; exp_seq[3] = 8'h00;
    start_frame();
    send_byte(8'h2A);
    checks++; if (tx_byte !== 8'h12) begin errors++; $display("FAIL rreg_first got %h want 12", tx_byte); end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFF);
      checks++; if (tx_byte !== exp_seq[i]) begin errors++; $display("FAIL rreg_byte%0d got %h want %h", i, tx_byte, exp_seq[i]); end
    end
    end_frame();
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rreg_idle_tx got %h want 00", tx_byte); end
  endtask

  task automatic test_write_mem_wrap();
    int base = mem_we_cnt;
    int bad  = 0;
    logic [11:0] ea;
    logic [7:0]  ed;
    start_frame();
    send_byte(8'h30);
    checks++; if (mem_we_cnt - base !== 0) begin errors++; $display("FAIL wmem_opcode_no_write got %0d want 0", mem_we_cnt - base); end
    for (int i = 0; i < 4097; i++) begin
      ea = i[11:0];
      ed = i[7:0];
      send_byte(ed);
      if ({last_mem_addr, last_mem_wdata} !== {ea, ed}) begin
        bad++;
        if (bad <= 5) $display("FAIL wmem_write%0d got addr %h data %h want addr %h data %h", i, last_mem_addr, last_mem_wdata, ea, ed);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wmem_sequence got %0d bad writes want 0", bad); end
    checks++; if (mem_we_cnt - base !== 4097) begin errors++; $display("FAIL wmem_count got %0d want 4097", mem_we_cnt - base); end
    checks++; if (last_mem_addr !== 12'h000) begin errors++; $display("FAIL wmem_wrap_addr got %h want 000", last_mem_addr); end
    end_frame();
  endtask

  task automatic test_read_mem();
    logic [7:0] exp_b;
    logic [11:0] exp_a;
    start_frame();
    send_byte(8'h40);
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rmem_addr0 got %h want 000", mem_addr); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rmem_tx0 got %h want 00", tx_byte); end
    for (int i = 1; i <= 3; i++) begin
      exp_b = i[7:0];
      exp_a = i[11:0];
      send_byte(8'hFF);
      checks++; if (mem_addr !== exp_a) begin errors++; $display("FAIL rmem_addr%0d got %h want %h", i, mem_addr, exp_a); end
      checks++; if (tx_byte !== exp_b) begin errors++; $display("FAIL rmem_tx%0d got %h want %h", i, tx_byte, exp_b); end
    end
    checks++; if (mem_we_cnt !== 4097) begin errors++; $display("FAIL rmem_no_write got %0d want 4097", mem_we_cnt); end
    end_frame();
  endtask

  task automatic test_abort_and_unknown();
    int rbase = reg_we_cnt;
    int ebase = cmd_err_cnt;
    start_frame();
    send_byte(8'h17);
    send_byte(8'h11);
    send_byte(8'h22);
    end_frame();
    checks++; if (reg_we_cnt - rbase !== 0) begin errors++; $display("FAIL abort_no_reg_we got %0d want 0", reg_we_cnt - rbase); end
    start_frame();
    send_byte(8'h90);
    checks++; if (cmd_err_cnt - ebase !== 1) begin errors++; $display("FAIL unknown_cmd_err got %0d want 1", cmd_err_cnt - ebase); end
    send_byte(8'h15);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if (reg_we_cnt - rbase !== 0) begin errors++; $display("FAIL discard_no_reg_we got %0d want 0", reg_we_cnt - rbase); end
    checks++; if (cmd_err_cnt - ebase !== 1) begin errors++; $display("FAIL discard_single_err got %0d want 1", cmd_err_cnt - ebase); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL discard_tx got %h want 00", tx_byte); end
    end_frame();
  endtask

  task automatic test_ignore_frame_low();
    int rbase = reg_we_cnt;
    int ebase = cmd_err_cnt;
    int mbase = mem_we_cnt;
    send_byte(8'h90);
    send_byte(8'h30);
    send_byte(8'hAA);
    checks++; if (cmd_err_cnt - ebase !== 0) begin errors++; $display("FAIL nofr_cmd_err got %0d want 0", cmd_err_cnt - ebase); end
    checks++; if ((mem_we_cnt - mbase) + (reg_we_cnt - rbase) !== 0) begin errors++; $display("FAIL nofr_writes got %0d want 0", (mem_we_cnt - mbase) + (reg_we_cnt - rbase)); end
  endtask

  task automatic test_reset_mid_wmem();
    int mbase = mem_we_cnt;
    start_frame();
    send_byte(8'h30);
    send_byte(8'hA1);
    send_byte(8'hA2);
    checks++; if (mem_we_cnt - mbase !== 2) begin errors++; $display("FAIL rst_pre_writes got %0d want 2", mem_we_cnt - mbase); end
    checks++; if (last_mem_addr !== 12'h001) begin errors++; $display("FAIL rst_pre_addr got %h want 001", last_mem_addr); end
    @(negedge SysClk);
    Reset_n = 1'b0;
    @(negedge SysClk);
    #1;
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_mem_addr got %h want 000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); end
    Reset_n = 1'b1;
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'h30);
    send_byte(8'hB3);
    checks++; if (mem_we_cnt - mbase !== 2) begin errors++; $display("FAIL rst_blocked_writes got %0d want 2", mem_we_cnt - mbase); end
    end_frame();
    start_frame();
    send_byte(8'h30);
    send_byte(8'hAB);
    checks++; if (mem_we_cnt - mbase !== 3) begin errors++; $display("FAIL rst_recover_count got %0d want 3", mem_we_cnt - mbase); end
    checks++; if ({last_mem_addr, last_mem_wdata} !== {12'h000, 8'hAB}) begin errors++; $display("FAIL rst_recover_write got %h/%h want 000/ab", last_mem_addr, last_mem_wdata); end
    end_frame();
  endtask

  initial begin
    Reset_n      = 1'b0;
    frame_active = 1'b0;
    rx_valid     = 1'b0;
    rx_byte      = 8'h00;
    for (int i = 0; i < 16; i++) reg_model[i] = 32'hA5A5_0000 | i;
    reg_model[10] = 32'h1234_5678;
    for (int n = 0; n < 4096; n++) mem_model[n] = n[7:0];

    test_reset();
    test_write_reg();
    test_read_reg();
    test_write_mem_wrap();
    test_read_mem();
    test_abort_and_unknown();
    test_ignore_frame_low();
    test_reset_mid_wmem();

    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL we_exclusive got %0d overlaps want 0", both_cnt); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
